// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS and optional IDCODE data register.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_tap_ir #(
  parameter int          IR_WIDTH     = 4,
  parameter int          IDCODE_OP    = 1,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [IR_WIDTH-1:0] IR,
  output logic [3:0]          State,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic                UserSel,
  input  logic                UserTDO
);

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] BYPASS_OP   = {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] IDCODE_OP_W = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_OP_W;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS_OP;
`endif

  // Parameter sanity: refuse to elaborate an unusable configuration.
  if ((IR_WIDTH < 2) || (IR_WIDTH > 8)) begin : g_bad_ir_width
    $error("jtag_tap_ir: IR_WIDTH must be in 2..8");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode_value
    $error("jtag_tap_ir: IDCODE_VALUE bit 0 must be 1");
  end
  if ((IDCODE_OP < 0) || (IDCODE_OP >= (1 << IR_WIDTH) - 1)) begin : g_bad_idcode_op
    $error("jtag_tap_ir: IDCODE_OP must fit IR_WIDTH and differ from BYPASS");
  end

  tap_state_t          state_reg;
  tap_state_t          state_next;
  logic [IR_WIDTH-1:0] ir_shift_reg;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [IR_WIDTH-1:0] ir_next;
  logic                bypass_reg;
  logic                tdo_reg;
  logic                tdo_next;
  logic                tdo_en_reg;
  logic                tdo_en_next;
  logic                bypass_sel;
  logic                idcode_sel;
  logic                user_sel;
  logic                idcode_bit;

  // ---------------------------------------------------------------------------
  // TAP state machine (posedge TCK)
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_reg <= TLR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = TLR;
    case (state_reg)
      TLR:        state_next = TMS ? TLR        : RUN_IDLE;
      RUN_IDLE:   state_next = TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  state_next = TMS ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: state_next = TMS ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   state_next = TMS ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   state_next = TMS ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   state_next = TMS ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   state_next = TMS ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  state_next = TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  state_next = TMS ? TLR        : CAPTURE_IR;
      CAPTURE_IR: state_next = TMS ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   state_next = TMS ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   state_next = TMS ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   state_next = TMS ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   state_next = TMS ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  state_next = TMS ? SELECT_DR  : RUN_IDLE;
      default:    state_next = TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data register selection decoded from the updated instruction
  // ---------------------------------------------------------------------------
`ifdef JTAG_TAP_IDCODE_EN
  assign bypass_sel = (ir_reg == BYPASS_OP);
  assign idcode_sel = (ir_reg == IDCODE_OP_W);
`else
  // Without the IDCODE register its opcode falls back to BYPASS behaviour.
  assign bypass_sel = (ir_reg == BYPASS_OP) || (ir_reg == IDCODE_OP_W);
  assign idcode_sel = 1'b0;
`endif
  assign user_sel = ~(bypass_sel | idcode_sel);

  // ---------------------------------------------------------------------------
  // Shift registers (posedge TCK); pause states simply hold contents
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_reg <= '0;
      bypass_reg   <= 1'b0;
    end else begin
      if (state_reg == CAPTURE_IR) begin
        ir_shift_reg <= IR_CAPTURE;
      end else if (state_reg == SHIFT_IR) begin
        ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
      end
      if (bypass_sel) begin
        if (state_reg == CAPTURE_DR) begin
          bypass_reg <= 1'b0;
        end else if (state_reg == SHIFT_DR) begin
          bypass_reg <= TDI;
        end
      end
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_reg;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_reg <= IDCODE_VALUE;
    end else if (idcode_sel) begin
      if (state_reg == CAPTURE_DR) begin
        idcode_reg <= IDCODE_VALUE;
      end else if (state_reg == SHIFT_DR) begin
        idcode_reg <= {TDI, idcode_reg[31:1]};
      end
    end
  end

  assign idcode_bit = idcode_reg[0];
`else
  assign idcode_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Instruction update and serial output (negedge TCK)
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_next = ir_reg;
    if (state_reg == UPDATE_IR) begin
      ir_next = ir_shift_reg;
    end else if (state_reg == TLR) begin
      ir_next = RESET_INSTR;
    end
  end

  always_comb begin
    tdo_next    = 1'b0;
    tdo_en_next = 1'b0;
    if (state_reg == SHIFT_IR) begin
      tdo_next    = ir_shift_reg[0];
      tdo_en_next = 1'b1;
    end else if (state_reg == SHIFT_DR) begin
      tdo_en_next = 1'b1;
      if (bypass_sel) begin
        tdo_next = bypass_reg;
      end else if (idcode_sel) begin
        tdo_next = idcode_bit;
      end else begin
        tdo_next = UserTDO;
      end
    end
  end

  // Launching on the falling edge gives the downstream device half a TCK of setup.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_reg     <= RESET_INSTR;
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else begin
      ir_reg     <= ir_next;
      tdo_reg    <= tdo_next;
      tdo_en_reg <= tdo_en_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign State     = state_reg;
  assign IR        = ir_reg;
  assign TDO       = tdo_reg;
  assign TDO_EN    = tdo_en_reg;
  assign UserSel   = user_sel;
  assign CaptureDR = (state_reg == CAPTURE_DR) && user_sel;
  assign ShiftDR   = (state_reg == SHIFT_DR) && user_sel;
  assign UpdateDR  = (state_reg == UPDATE_DR) && user_sel;

endmodule

// File: doc/jtag_tap_ir.md
JTAG_TAP_IR -- requirements
Module: jtag_tap_ir

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4: instruction register width, legal range 2..8.
REQ-002 SHALL have parameter IDCODE_OP, default 1: IDCODE opcode; BYPASS opcode is fixed at all-ones.
REQ-003 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001: device ID; bit 0 SHALL be 1, and the block SHALL fail elaboration otherwise.
REQ-004 SHALL have port TCK, input, 1 bit: the single clock. Posedge advances state and shift registers; negedge updates IR, TDO and TDO_EN.
REQ-005 SHALL have port TRST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port TMS, input, 1 bit: mode select, sampled on posedge TCK.
REQ-007 SHALL have port TDI, input, 1 bit: serial data in, sampled on posedge TCK.
REQ-008 SHALL have port TDO, output, 1 bit: serial data out, registered on negedge TCK.
REQ-009 SHALL have port TDO_EN, output, 1 bit: output enable, registered on negedge TCK.
REQ-010 SHALL have port IR, output, IR_WIDTH bits: the current (updated) instruction.
REQ-011 SHALL have port State, output, 4 bits: TAP state encoding.
REQ-012 SHALL have port CaptureDR, output, 1 bit: user-DR capture strobe.
REQ-013 SHALL have port ShiftDR, output, 1 bit: user-DR shift strobe.
REQ-014 SHALL have port UpdateDR, output, 1 bit: user-DR update strobe.
REQ-015 SHALL have port UserSel, output, 1 bit: high when IR is neither BYPASS nor IDCODE.
REQ-016 SHALL have port UserTDO, input, 1 bit: serial output of the user data register.

Function
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM on posedge TCK with this encoding: EXIT2_DR 0, EXIT1_DR 1, SHIFT_DR 2, PAUSE_DR 3, SELECT_IR 4, UPDATE_DR 5, CAPTURE_DR 6, SELECT_DR 7, EXIT2_IR 8, EXIT1_IR 9, SHIFT_IR A, PAUSE_IR B, RUN_IDLE C, UPDATE_IR D, CAPTURE_IR E, TLR F.
REQ-018 SHALL force any illegal state to TLR on the next posedge TCK.
REQ-019 SHALL, at posedge TCK while in CAPTURE_IR, load the IR shift register with binary ...0001 (bit0=1, bit1=0, all higher bits 0).
REQ-020 SHALL, at posedge TCK while in SHIFT_IR, shift the IR shift register right, with TDI entering bit IR_WIDTH-1.
REQ-021 SHALL, at negedge TCK while in UPDATE_IR, copy the IR shift register to IR; IR SHALL hold in all other states except TLR.
REQ-022 SHALL, at negedge TCK while in TLR, load IR with the reset instruction (see Configuration).
REQ-023 SHALL, when IR is BYPASS (or any unimplemented non-user opcode is selected), load the 1-bit bypass register with 0 in CAPTURE_DR and load it from TDI in SHIFT_DR.
REQ-024 SHALL, when IR is IDCODE, load the 32-bit IDCODE register with IDCODE_VALUE in CAPTURE_DR and shift it right with TDI into bit 31 in SHIFT_DR.
REQ-025 SHALL drive CaptureDR, ShiftDR and UpdateDR combinationally as (State==CAPTURE_DR/SHIFT_DR/UPDATE_DR) AND UserSel.
REQ-026 SHALL, at negedge TCK: in SHIFT_IR set TDO to IR-shift bit0; in SHIFT_DR set TDO to the selected DR bit0 (bypass, IDCODE, or UserTDO); in all other states set TDO to 0.
REQ-027 SHALL, at negedge TCK, set TDO_EN to 1 iff State is SHIFT_IR or SHIFT_DR.
REQ-028 SHALL make the first TDO bit of a scan the captured LSB, valid from the negedge after the posedge that enters SHIFT_xR.
REQ-029 SHALL reach TLR from any state after 5 consecutive posedges with TMS=1, with no TRST required.
REQ-030 SHALL, for a mid-scan exit through EXIT1/PAUSE/EXIT2, preserve the shift register contents and resume shifting unchanged on re-entering SHIFT.

Reset
REQ-031 SHALL, while TRST=1, immediately and asynchronously set State=F, IR=reset instruction, IR shift=0, bypass=0, IDCODE register=IDCODE_VALUE, TDO=0 and TDO_EN=0.
REQ-032 SHALL, on a TRST assertion mid-scan, abort the scan; IR SHALL NOT be updated with partial shift data.

Configuration
REQ-033 SHALL, with macro JTAG_TAP_IDCODE_EN defined, include the IDCODE register and use IDCODE_OP as the reset instruction.
REQ-034 SHALL, without JTAG_TAP_IDCODE_EN, omit the IDCODE register, use BYPASS as the reset instruction, and treat IDCODE_OP as BYPASS (UserSel=0).

Verification
REQ-035 SHALL be verified with: TRST pulse, then TMS=0 for one TCK -> State=C, IR=4'h1 (macro on) or 4'hF (macro off), TDO_EN=0.
REQ-036 SHALL be verified with: from SHIFT_DR, 5 posedges with TMS=1 -> State=F; IR = reset instruction after the next negedge.
REQ-037 SHALL be verified with: an IR scan shifting TDI 1,1,1,1 -> TDO 1,0,0,0; after UPDATE_IR, IR=4'hF and UserSel=0.
REQ-038 SHALL be verified with: IDCODE selected and a 32-bit DR scan -> TDO stream equals 32'h1000_0001, LSB first.
REQ-039 SHALL be verified with: BYPASS selected, TDI 1,0,1,1 in SHIFT_DR -> TDO 0,1,0,1 (one-bit delay).
REQ-040 SHALL be verified with: IR=4'h3 user opcode, DR scan -> CaptureDR high exactly 1 cycle, TDO follows UserTDO; TRST mid-scan -> TDO_EN=0 and State=F without waiting for TCK.
